axis_out_packer: RTL

//  Output-side packer between proc_engine_out and the AXI-Stream output, replacing fixed sign-pad + width adapter.

---
 rtl/axis_out_packer_if.sv | 27 ++
 rtl/axis_out_packer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_out_packer_if.sv
// Stream bundle for axis_out_packer: the ROWS-lane input beat channel and the packed AXI-Stream output.
// The packer takes the slave view; whoever feeds beats and accepts words takes the master view.
interface axis_out_packer_if #(
    parameter int ROWS    = 8,
    parameter int Y_BITS  = 24,
    parameter int M_WIDTH = 128
);
    logic                   s_valid;
    logic                   s_ready;
    logic [ROWS*Y_BITS-1:0] s_data;
    logic                   s_last;
    logic                   m_axis_tvalid;
    logic                   m_axis_tready;
    logic [M_WIDTH-1:0]     m_axis_tdata;
    logic [M_WIDTH/8-1:0]   m_axis_tkeep;
    logic                   m_axis_tlast;

    modport slave (
        input  s_valid, s_data, s_last, m_axis_tready,
        output s_ready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast
    );

    modport master (
        output s_valid, s_data, s_last, m_axis_tready,
        input  s_ready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast
    );
endinterface

// File: rtl/axis_out_packer.sv
// Output packer: saturates ROWS signed lanes to a runtime element width and packs them
// little-endian into M_WIDTH-bit AXI-Stream words, collecting narrow beats or splitting wide ones.
module axis_out_packer #(
    parameter int ROWS    = 8,
    parameter int Y_BITS  = 24,
    parameter int M_WIDTH = 128
) (
    input  logic             aclk,
    input  logic             rst,
    input  logic [1:0]       cfg_mode,
    output logic             sat_flag,
    axis_out_packer_if.slave bus
);
    localparam int BEAT_W = ROWS * 32;
    localparam int KEEP_W = M_WIDTH / 8;
    localparam int CNT_W  = $clog2(M_WIDTH / 8) + 1;
    localparam int SIDX_W = $clog2(ROWS) + 1;
    localparam int IN_W8  = ROWS * 8;
    localparam int IN_W16 = ROWS * 16;
    localparam int IN_W32 = ROWS * 32;
    localparam int N8     = (IN_W8  < M_WIDTH) ? M_WIDTH / IN_W8  : 1;
    localparam int N16    = (IN_W16 < M_WIDTH) ? M_WIDTH / IN_W16 : 1;
    localparam int N32    = (IN_W32 < M_WIDTH) ? M_WIDTH / IN_W32 : 1;
    localparam int K8     = (IN_W8  > M_WIDTH) ? IN_W8  / M_WIDTH : 1;
    localparam int K16    = (IN_W16 > M_WIDTH) ? IN_W16 / M_WIDTH : 1;
    localparam int K32    = (IN_W32 > M_WIDTH) ? IN_W32 / M_WIDTH : 1;

    typedef enum logic [0:0] {
        ST_FILL  = 1'b0,
        ST_SPLIT = 1'b1
    } state_t;

    // Returns {clamped, value sign-extended to 32b} for one lane at the element width of mode.
    function automatic logic [32:0] convert_lane(input logic [Y_BITS-1:0] lane, input logic [1:0] mode);
        logic signed [31:0] v;
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        logic [32:0]        res;
        v = 32'(signed'(lane));
        case (mode)
            2'd0: begin
                hi = 32'sd127;
                lo = -32'sd128;
            end
            2'd1: begin
                hi = 32'sd32767;
                lo = -32'sd32768;
            end
            default: begin
                hi = 32'sh7fffffff;
                lo = 32'sh80000000;
            end
        endcase
        if (v > hi) begin
            res = {1'b1, hi};
        end else if (v < lo) begin
            res = {1'b1, lo};
        end else begin
            res = {1'b0, v};
        end
        return res;
    endfunction

    state_t              state_r;
    logic                run_r;
    logic                in_pkt_r;
    logic [1:0]          mode_r;
    logic                sat_r;
    logic [M_WIDTH-1:0]  acc_r;
    logic [CNT_W-1:0]    fill_cnt_r;
    logic                word_wait_r;
    logic [KEEP_W-1:0]   wait_keep_r;
    logic                wait_last_r;
    logic [BEAT_W-1:0]   split_r;
    logic [SIDX_W-1:0]   slice_idx_r;
    logic [SIDX_W-1:0]   k_r;
    logic                split_last_r;
    logic                tvalid_r;
    logic [M_WIDTH-1:0]  tdata_r;
    logic [KEEP_W-1:0]   tkeep_r;
    logic                tlast_r;

    logic [1:0]          mode_eff_s;
    logic [31:0]         in_bytes_s;
    logic [CNT_W-1:0]    n_beats_s;
    logic [SIDX_W-1:0]   k_slices_s;
    logic                is_split_s;
    logic [32:0]         lane_conv_s [ROWS];
    logic [BEAT_W-1:0]   beat_s;
    logic                beat_sat_s;
    logic [31:0]         fill_pos_s;
    logic [31:0]         filled_bytes_s;
    logic [M_WIDTH-1:0]  acc_next_s;
    logic [CNT_W-1:0]    cnt_next_s;
    logic                fill_done_s;
    logic [KEEP_W-1:0]   keep_next_s;
    logic [M_WIDTH-1:0]  slice_s;
    logic                s_ready_s;
    logic                out_free_s;
    logic                accept_s;

    // The first beat of a packet uses the live cfg_mode; later beats use the latched one.
    always_comb begin
        mode_eff_s = in_pkt_r ? mode_r : cfg_mode;
        case (mode_eff_s)
            2'd0: begin
                in_bytes_s = 32'(ROWS);
                n_beats_s  = CNT_W'(N8);
                k_slices_s = SIDX_W'(K8);
            end
            2'd1: begin
                in_bytes_s = 32'(ROWS * 2);
                n_beats_s  = CNT_W'(N16);
                k_slices_s = SIDX_W'(K16);
            end
            default: begin
                in_bytes_s = 32'(ROWS * 4);
                n_beats_s  = CNT_W'(N32);
                k_slices_s = SIDX_W'(K32);
            end
        endcase
        is_split_s = (k_slices_s != SIDX_W'(1));
    end

    // Per-lane saturation, then lane i is placed at element slot i of the beat.
    always_comb begin
        beat_s     = '0;
        beat_sat_s = 1'b0;
        for (int i = 0; i < ROWS; i++) begin
            lane_conv_s[i] = convert_lane(bus.s_data[Y_BITS*i +: Y_BITS], mode_eff_s);
            beat_sat_s     = beat_sat_s | lane_conv_s[i][32];
            case (mode_eff_s)
                2'd0:    beat_s[8*i +: 8]   = lane_conv_s[i][7:0];
                2'd1:    beat_s[16*i +: 16] = lane_conv_s[i][15:0];
                default: beat_s[32*i +: 32] = lane_conv_s[i][31:0];
            endcase
        end
    end

    // Accumulator update, word-complete detection and byte enables for the word being built.
    always_comb begin
        fill_pos_s     = 32'(fill_cnt_r) * in_bytes_s * 32'd8;
        acc_next_s     = acc_r | (M_WIDTH'(beat_s) << fill_pos_s);
        cnt_next_s     = fill_cnt_r + CNT_W'(1);
        fill_done_s    = (cnt_next_s == n_beats_s) || bus.s_last;
        filled_bytes_s = 32'(cnt_next_s) * in_bytes_s;
        for (int b = 0; b < KEEP_W; b++) begin
            keep_next_s[b] = (32'(b) < filled_bytes_s);
        end
        slice_s = M_WIDTH'(split_r >> (32'(slice_idx_r) * 32'(M_WIDTH)));
    end

    // Handshake qualifiers; s_ready never looks at s_valid.
    always_comb begin
        if (run_r && (state_r == ST_FILL) && !word_wait_r) begin
            s_ready_s = 1'b1;
        end else begin
            s_ready_s = 1'b0;
        end
        out_free_s = !tvalid_r || bus.m_axis_tready;
        accept_s   = bus.s_valid && s_ready_s;
    end

    // Packet bookkeeping, FILL/SPLIT sequencing and the single output register stage.
    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_FILL;
            run_r        <= 1'b0;
            in_pkt_r     <= 1'b0;
            mode_r       <= 2'd0;
            sat_r        <= 1'b0;
            acc_r        <= '0;
            fill_cnt_r   <= '0;
            word_wait_r  <= 1'b0;
            wait_keep_r  <= '0;
            wait_last_r  <= 1'b0;
            split_r      <= '0;
            slice_idx_r  <= '0;
            k_r          <= '0;
            split_last_r <= 1'b0;
            tvalid_r     <= 1'b0;
            tdata_r      <= '0;
            tkeep_r      <= '0;
            tlast_r      <= 1'b0;
        end else begin
            run_r <= 1'b1;
            if (tvalid_r && bus.m_axis_tready) begin
                tvalid_r <= 1'b0;
            end
            if (accept_s) begin
                in_pkt_r <= !bus.s_last;
                if (!in_pkt_r) begin
                    mode_r <= cfg_mode;
                    sat_r  <= beat_sat_s;
                end else begin
                    sat_r  <= sat_r | beat_sat_s;
                end
            end
            case (state_r)
                ST_FILL: begin
                    if (word_wait_r) begin
                        if (out_free_s) begin
                            tvalid_r    <= 1'b1;
                            tdata_r     <= acc_r;
                            tkeep_r     <= wait_keep_r;
                            tlast_r     <= wait_last_r;
                            acc_r       <= '0;
                            word_wait_r <= 1'b0;
                        end
                    end else if (accept_s) begin
                        if (is_split_s) begin
                            split_r      <= beat_s;
                            split_last_r <= bus.s_last;
                            k_r          <= k_slices_s;
                            state_r      <= ST_SPLIT;
                            if (out_free_s) begin
                                tvalid_r    <= 1'b1;
                                tdata_r     <= M_WIDTH'(beat_s);
                                tkeep_r     <= '1;
                                tlast_r     <= 1'b0;
                                slice_idx_r <= SIDX_W'(1);
                            end else begin
                                slice_idx_r <= '0;
                            end
                        end else if (fill_done_s) begin
                            fill_cnt_r <= '0;
                            if (out_free_s) begin
                                tvalid_r <= 1'b1;
                                tdata_r  <= acc_next_s;
                                tkeep_r  <= keep_next_s;
                                tlast_r  <= bus.s_last;
                                acc_r    <= '0;
                            end else begin
                                // Completed word parks in the accumulator behind the held output.
                                acc_r       <= acc_next_s;
                                wait_keep_r <= keep_next_s;
                                wait_last_r <= bus.s_last;
                                word_wait_r <= 1'b1;
                            end
                        end else begin
                            acc_r      <= acc_next_s;
                            fill_cnt_r <= cnt_next_s;
                        end
                    end
                end
                ST_SPLIT: begin
                    if (out_free_s) begin
                        tvalid_r    <= 1'b1;
                        tdata_r     <= slice_s;
                        tkeep_r     <= '1;
                        tlast_r     <= split_last_r && (slice_idx_r == k_r - SIDX_W'(1));
                        slice_idx_r <= slice_idx_r + SIDX_W'(1);
                        if (slice_idx_r == k_r - SIDX_W'(1)) begin
                            state_r <= ST_FILL;
                        end
                    end
                end
                default: begin
                    state_r <= ST_FILL;
                end
            endcase
        end
    end

    assign bus.s_ready       = s_ready_s;
    assign bus.m_axis_tvalid = tvalid_r;
    assign bus.m_axis_tdata  = tdata_r;
    assign bus.m_axis_tkeep  = tkeep_r;
    assign bus.m_axis_tlast  = tlast_r;
    assign sat_flag          = sat_r;

endmodule
